// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: word width,
// DMA direction encoding and arbiter state encoding.
package dmem_port_arbiter_pkg;

  localparam int WORD = 32;
  localparam logic [WORD-1:0] WORD_STEP = 32'd4;

  // DMA_WR moves data into memory, DMA_RD moves data out of memory
  typedef enum logic {
    DMA_WR = 1'b0,
    DMA_RD = 1'b1
  } dmaDir_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_BURST = 2'd1,
    ARB_DONE  = 2'd2
  } arbState_t;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of CPU MEM-stage, DMA burst and data_mem signals around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface dmem_port_arbiter_if #(
  parameter int LEN_W = 10
);
  import dmem_port_arbiter_pkg::*;

  logic             cpu_read;
  logic             cpu_write;
  logic [WORD-1:0]  cpu_addr;
  logic [WORD-1:0]  cpu_wdata;
  logic [WORD-1:0]  cpu_rdata;
  logic             cpu_stall;

  logic             dma_start;
  logic             dma_dir;
  logic [WORD-1:0]  dma_base;
  logic [LEN_W-1:0] dma_len;
  logic             dma_busy;
  logic             dma_done;
  logic [WORD-1:0]  dma_wdata;
  logic             dma_wvalid;
  logic             dma_wready;
  logic [WORD-1:0]  dma_rdata;
  logic             dma_rvalid;
  logic             dma_rready;

  logic             mem_read;
  logic             mem_write;
  logic [WORD-1:0]  mem_address;
  logic [WORD-1:0]  mem_write_data;
  logic [WORD-1:0]  mem_read_data;

  modport slave (
    input  cpu_read, cpu_write, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dma_start, dma_dir, dma_base, dma_len, dma_wdata, dma_wvalid, dma_rready,
    output dma_busy, dma_done, dma_wready, dma_rdata, dma_rvalid,
    output mem_read, mem_write, mem_address, mem_write_data,
    input  mem_read_data
  );

  modport master (
    output cpu_read, cpu_write, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dma_start, dma_dir, dma_base, dma_len, dma_wdata, dma_wvalid, dma_rready,
    input  dma_busy, dma_done, dma_wready, dma_rdata, dma_rvalid,
    input  mem_read, mem_write, mem_address, mem_write_data,
    output mem_read_data
  );

endinterface

// File: rtl/dmem_port_arbiter_burst_counter.sv
// Address and remaining-word tracker for one DMA burst. Loaded at burst
// start, stepped once per granted beat; last flags the final beat.
module dma_burst_counter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int LEN_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WORD-1:0]  baseAddr,
  input  logic [LEN_W-1:0] len,
  output logic [WORD-1:0]  addr,
  output logic             last
);

  logic [LEN_W-1:0] remaining;

  // Address advances one word per beat and wraps naturally at the word width
  always_ff @(posedge clk) begin
    if (reset) begin
      addr      <= '0;
      remaining <= '0;
    end else if (load) begin
      addr      <= baseAddr;
      remaining <= len;
    end else if (step) begin
      addr      <= addr + WORD_STEP;
      remaining <= remaining - LEN_W'(1);
    end
  end

  assign last = (remaining == LEN_W'(1));

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single data-memory port between the CPU MEM stage and a burst
// DMA engine. The CPU wins by default; a blocked DMA beat is forced through
// (stalling the CPU for one cycle) once it has waited MAX_WAIT cycles.
module dmem_port_arbiter #(
  parameter int LEN_W    = 10,
  parameter int MAX_WAIT = 4
) (
  input  logic               clk,
  input  logic               reset,
  dmem_port_arbiter_if.slave bus
);
  import dmem_port_arbiter_pkg::*;

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  arbState_t         state;
  dmaDir_t           dirQ;
  logic [WAIT_W-1:0] waitCnt;

  logic              cpuReq;
  logic              dmaReadyBeat;
  logic              dmaGnt;
  logic              cpuGnt;
  logic              burstLoad;
  logic              burstLast;
  logic [WORD-1:0]   burstAddr;

  assign cpuReq       = bus.cpu_read | bus.cpu_write;
  assign dmaReadyBeat = (state == ARB_BURST) &
                        ((dirQ == DMA_WR) ? bus.dma_wvalid : bus.dma_rready);
  assign dmaGnt       = dmaReadyBeat & (~cpuReq | (waitCnt == WAIT_W'(MAX_WAIT)));
  assign cpuGnt       = cpuReq & ~dmaGnt;
  assign burstLoad    = (state == ARB_IDLE) & bus.dma_start & (bus.dma_len != '0);

  dma_burst_counter #(.LEN_W(LEN_W)) burstCounter (
    .clk      (clk),
    .reset    (reset),
    .load     (burstLoad),
    .step     (dmaGnt),
    .baseAddr (bus.dma_base),
    .len      (bus.dma_len),
    .addr     (burstAddr),
    .last     (burstLast)
  );

  // Burst sequencing plus the starvation counter that forces a DMA beat
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ARB_IDLE;
      dirQ    <= DMA_WR;
      waitCnt <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (bus.dma_start) begin
            if (bus.dma_len != '0) begin
              dirQ  <= dmaDir_t'(bus.dma_dir);
              state <= ARB_BURST;
            end else begin
              state <= ARB_DONE;
            end
          end
        end
        ARB_BURST: begin
          if (dmaGnt && burstLast) begin
            state <= ARB_DONE;
          end
        end
        ARB_DONE: state <= ARB_IDLE;
        default:  state <= ARB_IDLE;
      endcase

      if ((state == ARB_IDLE) || dmaGnt) begin
        waitCnt <= '0;
      end else if (dmaReadyBeat && cpuGnt) begin
        waitCnt <= waitCnt + WAIT_W'(1);
      end
    end
  end

  assign bus.cpu_stall = cpuReq & dmaGnt;
  assign bus.dma_busy  = (state != ARB_IDLE);
  assign bus.dma_done  = (state == ARB_DONE);

  // Steer the memory port to whichever side holds the grant this cycle
  always_comb begin
    bus.mem_read       = 1'b0;
    bus.mem_write      = 1'b0;
    bus.mem_address    = '0;
    bus.mem_write_data = '0;
    bus.cpu_rdata      = '0;
    bus.dma_wready     = 1'b0;
    bus.dma_rvalid     = 1'b0;
    bus.dma_rdata      = '0;
    if (cpuGnt) begin
      bus.mem_read       = bus.cpu_read;
      bus.mem_write      = bus.cpu_write;
      bus.mem_address    = bus.cpu_addr;
      bus.mem_write_data = bus.cpu_wdata;
      bus.cpu_rdata      = bus.mem_read_data;
    end else if (dmaGnt) begin
      bus.mem_address = burstAddr;
      if (dirQ == DMA_WR) begin
        bus.mem_write      = 1'b1;
        bus.mem_write_data = bus.dma_wdata;
        bus.dma_wready     = 1'b1;
      end else begin
        bus.mem_read   = 1'b1;
        bus.dma_rvalid = 1'b1;
        bus.dma_rdata  = bus.mem_read_data;
      end
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter. Stimulus pushes the expected port
// activity into a queue; a monitor pops and compares on every active cycle.
module tb_dmem_port_arbiter;

  logic clk;
  logic reset;

  dmem_port_arbiter_if #(.LEN_W(10)) bus ();

  dmem_port_arbiter #(.LEN_W(10), .MAX_WAIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  localparam logic [5:0] CTL_RD   = 6'b100000;
  localparam logic [5:0] CTL_WR   = 6'b010000;
  localparam logic [5:0] CTL_STL  = 6'b001000;
  localparam logic [5:0] CTL_DONE = 6'b000100;
  localparam logic [5:0] CTL_RV   = 6'b000010;
  localparam logic [5:0] CTL_WRDY = 6'b000001;

  typedef struct packed {
    logic [5:0]  ctl;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  rsel;
    logic [31:0] rdata;
  } ev_t;

  ev_t expQ[$];
  int  total = 0;
  int  bad   = 0;

  logic [31:0] memArr [0:255];
  logic        memReady;

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory model: async read, sync write, filled with a pattern once
  assign bus.mem_read_data = memArr[bus.mem_address[9:2]];
  always @(posedge clk) begin
    if (reset && !memReady) begin
      for (int i = 0; i < 256; i++) memArr[i] <= 32'hC000_0000 | 32'(i);
      memReady <= 1'b1;
    end else if (bus.mem_write) begin
      memArr[bus.mem_address[9:2]] <= bus.mem_write_data;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic ev_t mk(input logic [5:0] ctl, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [1:0] rsel,
                             input logic [31:0] rdata);
    ev_t e;
    e.ctl = ctl; e.addr = addr; e.wdata = wdata; e.rsel = rsel; e.rdata = rdata;
    return e;
  endfunction

  task automatic driveInputs(input logic cRd, input logic cWr, input logic [31:0] cAddr,
                             input logic [31:0] cWdata, input logic st, input logic dir,
                             input logic [31:0] base, input logic [9:0] len,
                             input logic wv, input logic [31:0] wd, input logic rr);
    bus.cpu_read   = cRd;
    bus.cpu_write  = cWr;
    bus.cpu_addr   = cAddr;
    bus.cpu_wdata  = cWdata;
    bus.dma_start  = st;
    bus.dma_dir    = dir;
    bus.dma_base   = base;
    bus.dma_len    = len;
    bus.dma_wvalid = wv;
    bus.dma_wdata  = wd;
    bus.dma_rready = rr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic cRd, input logic cWr, input logic [31:0] cAddr,
                               input logic [31:0] cWdata, input logic st, input logic dir,
                               input logic [31:0] base, input logic [9:0] len,
                               input logic wv, input logic [31:0] wd, input logic rr);
    driveInputs(cRd, cWr, cAddr, cWdata, st, dir, base, len, wv, wd, rr);
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every cycle with port activity must match the next expected event
  initial begin
    ev_t         e;
    logic [5:0]  actCtl;
    int          evIdx;
    evIdx = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        actCtl = {bus.mem_read, bus.mem_write, bus.cpu_stall, bus.dma_done,
                  bus.dma_rvalid, bus.dma_wready};
        if (actCtl != 6'b0) begin
          if (expQ.size() == 0) begin
            checkOutput($sformatf("spurious activity ctl after ev%0d", evIdx), 32'(actCtl), 32'h0);
          end else begin
            e = expQ.pop_front();
            checkOutput($sformatf("ev%0d ctl", evIdx), 32'(actCtl), 32'(e.ctl));
            checkOutput($sformatf("ev%0d addr", evIdx), bus.mem_address, e.addr);
            checkOutput($sformatf("ev%0d wdata", evIdx), bus.mem_write_data, e.wdata);
            if (e.rsel == 2'd1) checkOutput($sformatf("ev%0d cpu_rdata", evIdx), bus.cpu_rdata, e.rdata);
            if (e.rsel == 2'd2) checkOutput($sformatf("ev%0d dma_rdata", evIdx), bus.dma_rdata, e.rdata);
            evIdx++;
          end
        end
      end
    end
  end

  // Safety net so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  // Directed stimulus
  initial begin
    memReady = 1'b0;
    reset = 1'b1;
    driveInputs(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("reset mem_read", 32'(bus.mem_read), 32'h0);
    checkOutput("reset mem_write", 32'(bus.mem_write), 32'h0);
    checkOutput("reset mem_address", bus.mem_address, 32'h0);
    checkOutput("reset cpu_stall", 32'(bus.cpu_stall), 32'h0);
    checkOutput("reset dma_busy", 32'(bus.dma_busy), 32'h0);
    checkOutput("reset dma_done", 32'(bus.dma_done), 32'h0);
    checkOutput("reset dma_wready", 32'(bus.dma_wready), 32'h0);
    checkOutput("reset dma_rvalid", 32'(bus.dma_rvalid), 32'h0);
    tick();

    $display("[TB] case 1: CPU store then load");
    expQ.push_back(mk(CTL_WR, 32'h10, 32'h1234, 2'd0, 32'h0));
    expQ.push_back(mk(CTL_RD, 32'h10, 32'h0, 2'd1, 32'h1234));
    applyStimulus(0, 1, 32'h10, 32'h1234, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 32'h10, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    $display("[TB] case 2: write burst with idle CPU");
    expQ.push_back(mk(CTL_WR | CTL_WRDY, 32'h40, 32'hD001, 2'd0, 32'h0));
    expQ.push_back(mk(CTL_WR | CTL_WRDY, 32'h44, 32'hD002, 2'd0, 32'h0));
    expQ.push_back(mk(CTL_WR | CTL_WRDY, 32'h48, 32'hD003, 2'd0, 32'h0));
    expQ.push_back(mk(CTL_DONE, 32'h0, 32'h0, 2'd0, 32'h0));
    applyStimulus(0, 0, 0, 0, 1, 0, 32'h40, 10'd3, 1, 32'hD001, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hD001, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hD002, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hD003, 0);
    idle(2);

    $display("[TB] case 3: read burst with consumer backpressure");
    expQ.push_back(mk(CTL_RD | CTL_RV, 32'h40, 32'h0, 2'd2, 32'hD001));
    expQ.push_back(mk(CTL_RD | CTL_RV, 32'h44, 32'h0, 2'd2, 32'hD002));
    expQ.push_back(mk(CTL_RD | CTL_RV, 32'h48, 32'h0, 2'd2, 32'hD003));
    expQ.push_back(mk(CTL_RD | CTL_RV, 32'h4C, 32'h0, 2'd2, 32'hC000_0013));
    expQ.push_back(mk(CTL_DONE, 32'h0, 32'h0, 2'd0, 32'h0));
    applyStimulus(0, 0, 0, 0, 1, 1, 32'h40, 10'd4, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    driveInputs(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("case3 busy while rready low", 32'(bus.dma_busy), 32'h1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(2);

    $display("[TB] case 4: starvation forces DMA beats under constant CPU load");
    for (int c = 0; c < 12; c++) begin
      if (c == 5)       expQ.push_back(mk(CTL_WR | CTL_STL | CTL_WRDY, 32'h200, 32'hE1, 2'd0, 32'h0));
      else if (c == 10) expQ.push_back(mk(CTL_WR | CTL_STL | CTL_WRDY, 32'h204, 32'hE2, 2'd0, 32'h0));
      else if (c == 11) expQ.push_back(mk(CTL_RD | CTL_DONE, 32'h100, 32'h0, 2'd1, 32'hC000_0040));
      else              expQ.push_back(mk(CTL_RD, 32'h100, 32'h0, 2'd1, 32'hC000_0040));
    end
    for (int c = 0; c < 12; c++) begin
      applyStimulus(1, 0, 32'h100, 0, (c == 0), 0, 32'h200, 10'd2,
                    (c < 11), (c <= 5) ? 32'hE1 : 32'hE2, 0);
    end
    idle(2);

    $display("[TB] case 5: zero-length start and start while busy");
    expQ.push_back(mk(CTL_DONE, 32'h0, 32'h0, 2'd0, 32'h0));
    expQ.push_back(mk(CTL_WR | CTL_WRDY, 32'h300, 32'hF5, 2'd0, 32'h0));
    expQ.push_back(mk(CTL_DONE, 32'h0, 32'h0, 2'd0, 32'h0));
    applyStimulus(0, 0, 0, 0, 1, 0, 32'h300, 10'd0, 0, 0, 0);
    driveInputs(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("case5 busy during done", 32'(bus.dma_busy), 32'h1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 32'h300, 10'd1, 0, 0, 0);
    driveInputs(0, 0, 0, 0, 1, 1, 32'h0, 10'd5, 0, 0, 1);
    @(negedge clk);
    checkOutput("case5 busy in burst", 32'(bus.dma_busy), 32'h1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hF5, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    driveInputs(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("case5 idle after done", 32'(bus.dma_busy), 32'h0);
    tick();

    $display("[TB] case 6: reset aborts a burst");
    expQ.push_back(mk(CTL_WR | CTL_WRDY, 32'h180, 32'h61, 2'd0, 32'h0));
    applyStimulus(0, 0, 0, 0, 1, 0, 32'h180, 10'd5, 1, 32'h61, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h61, 0);
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    driveInputs(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h62, 0);
    @(negedge clk);
    checkOutput("case6 mem_write after reset", 32'(bus.mem_write), 32'h0);
    checkOutput("case6 mem_address after reset", bus.mem_address, 32'h0);
    checkOutput("case6 busy after reset", 32'(bus.dma_busy), 32'h0);
    checkOutput("case6 done after reset", 32'(bus.dma_done), 32'h0);
    checkOutput("case6 wready after reset", 32'(bus.dma_wready), 32'h0);
    tick();
    idle(1);
    expQ.push_back(mk(CTL_RD | CTL_RV, 32'h180, 32'h0, 2'd2, 32'h61));
    expQ.push_back(mk(CTL_DONE, 32'h0, 32'h0, 2'd0, 32'h0));
    applyStimulus(0, 0, 0, 0, 1, 1, 32'h180, 10'd1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(3);

    checkOutput("scoreboard drained", 32'(expQ.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
